// File: rtl/sram128x4_req_ctrl.sv
// Valid/ready front-end for the 128x4 single-port SRAM macro: post-reset clear
// sweep, credit-based request throttling and a small read-response FIFO.
module sram128x4_req_ctrl #(
    parameter int unsigned       ADDR_W     = 7,
    parameter int unsigned       DATA_W     = 4,
    parameter int unsigned       RESP_DEPTH = 3,
    parameter int unsigned       INIT_EN    = 1,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic              mem_ce,
    output logic              mem_csb,
    output logic              mem_web,
    output logic              mem_oeb,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] mem_o
);

    localparam int unsigned      PTR_W    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned      CRD_W    = $clog2(RESP_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);
    localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(RESP_DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam state_e RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              wr_ret_q, wr_ret_d;
    logic [CRD_W-1:0]  credits_q, credits_d;
    logic [CRD_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [DATA_W-1:0] fifo_q [RESP_DEPTH];
    logic [DATA_W-1:0] fifo_d [RESP_DEPTH];

    logic run;
    logic accept;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign run        = (state_q == ST_RUN);
    // Reset gates req_ready directly so INIT_EN=0 (reset state RUN) still idles.
    assign req_ready  = run & (credits_q != '0) & ~reset;
    assign accept     = req_valid & req_ready;
    assign push       = rd_pend_q;
    assign resp_valid = (count_q != '0);
    assign pop        = resp_valid & resp_ready;
    assign resp_rdata = fifo_q[rptr_q];
    assign init_done  = run;
    assign mem_ce     = clock;
    assign mem_oeb    = reset | ~rd_pend_q;

    always_comb begin
        mem_csb = 1'b1;
        mem_web = 1'b1;
        mem_a   = '0;
        mem_i   = '0;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                mem_csb = 1'b0;
                mem_web = 1'b0;
                mem_a   = cnt_q;
                mem_i   = INIT_VAL;
            end else begin
                mem_csb = ~accept;
                mem_web = ~req_write;
                mem_a   = req_addr;
                mem_i   = req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end

        rd_pend_d = accept & ~req_write;
        wr_ret_d  = accept & req_write;
        // Writes hold their credit for one cycle so reads and writes share one budget.
        credits_d = credits_q - CRD_W'(accept) + CRD_W'(pop) + CRD_W'(wr_ret_q);

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wptr_q] = mem_o;
        end
        wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q + CRD_W'(push) - CRD_W'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            wr_ret_q  <= 1'b0;
            credits_q <= CRD_FULL;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            for (int unsigned i = 0; i < RESP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            wr_ret_q  <= wr_ret_d;
            credits_q <= credits_d;
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            fifo_q    <= fifo_d;
        end
    end

endmodule

// File: tb/tb_sram128x4_req_ctrl.sv
// Directed bench for sram128x4_req_ctrl with a behavioural 128x4 macro attached.
`timescale 1ns/1ps
module tb_sram128x4_req_ctrl;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 4;
    localparam int unsigned RD = 3;

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          init_done;
    logic          mem_ce;
    logic          mem_csb;
    logic          mem_web;
    logic          mem_oeb;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_i;
    wire  [DW-1:0] mem_o;

    sram128x4_req_ctrl #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RESP_DEPTH(RD),
        .INIT_EN   (1),
        .INIT_VAL  (4'hA)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .init_done (init_done),
        .mem_ce    (mem_ce),
        .mem_csb   (mem_csb),
        .mem_web   (mem_web),
        .mem_oeb   (mem_oeb),
        .mem_a     (mem_a),
        .mem_i     (mem_i),
        .mem_o     (mem_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural macro: synchronous access on mem_ce, output tri-stated by mem_oeb.
    logic [DW-1:0] macro_mem [1 << AW];
    logic [DW-1:0] macro_dout;
    always @(posedge mem_ce) begin
        if (!mem_csb) begin
            if (!mem_web) macro_mem[mem_a] <= mem_i;
            else          macro_dout <= macro_mem[mem_a];
        end
    end
    assign mem_o = mem_oeb ? {DW{1'bz}} : macro_dout;

    int unsigned   n_pass = 0;
    int unsigned   n_chk  = 0;
    int unsigned   cyc    = 0;
    logic [DW-1:0] exp_mem [1 << AW];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    int unsigned   got_cyc_q [$];
    int unsigned   acc_cyc_q [$];
    int            outstanding = 0;
    int            max_out = 0;
    int unsigned   oeb_bad = 0;
    logic          rd_acc_prev = 1'b0;
    logic          bp_run = 1'b0;

    always @(posedge clock) cyc++;

    // Handshakes are sampled at negedge; they complete at the following posedge (cyc+1).
    always @(negedge clock) begin
        if (reset) begin
            outstanding = 0;
            rd_acc_prev = 1'b0;
        end else begin
            if (mem_oeb !== !rd_acc_prev) oeb_bad++;
            if (resp_valid && resp_ready) begin
                got_q.push_back(resp_rdata);
                got_cyc_q.push_back(cyc + 1);
                outstanding--;
            end
            rd_acc_prev = req_valid && req_ready && !req_write;
            if (rd_acc_prev) begin
                acc_cyc_q.push_back(cyc + 1);
                outstanding++;
            end
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int unsigned w = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        #1;
        while (!req_ready && w < 200) begin
            tick();
            #1;
            w++;
        end
        if (!req_ready) check("issue_ready", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        if (wr) exp_mem[a] = d;
        else    exp_q.push_back(exp_mem[a]);
    endtask

    task automatic drain_check(input string tag);
        int unsigned w = 0;
        while (got_q.size() < exp_q.size() && w < 300) begin
            tick();
            w++;
        end
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, 32'(got_q[i]), 32'(exp_q[i]));
        clear_queues();
    endtask

    task automatic wait_init(input string tag);
        int unsigned n = 0;
        while (!init_done && n < 300) begin
            tick();
            n++;
        end
        check(tag, n, 128);
        for (int i = 0; i < (1 << AW); i++) exp_mem[i] = 4'hA;
    endtask

    initial begin
        int unsigned drops;
        int unsigned w;
        int unsigned n;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            macro_mem[i] = 4'h3;
            exp_mem[i]   = 4'h3;
        end

        #12;
        check("rst_req_ready",  32'(req_ready),  0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_init_done",  32'(init_done),  0);
        check("rst_mem_csb",    32'(mem_csb),    1);
        check("rst_mem_web",    32'(mem_web),    1);
        check("rst_mem_oeb",    32'(mem_oeb),    1);
        check("rst_mem_a",      32'(mem_a),      0);
        check("rst_mem_i",      32'(mem_i),      0);

        // Clear sweep
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("sweep0_csb", 32'(mem_csb), 0);
        check("sweep0_web", 32'(mem_web), 0);
        check("sweep0_a",   32'(mem_a),   0);
        check("sweep0_i",   32'(mem_i),   'hA);
        n = 0;
        while (!init_done && n < 300) begin
            tick();
            n++;
            if (n == 50) begin
                check("sweep50_a",     32'(mem_a),     50);
                check("sweep50_ready", 32'(req_ready), 0);
            end
        end
        check("init_cycles", n, 128);
        for (int i = 0; i < (1 << AW); i++) exp_mem[i] = 4'hA;
        check("run_ready", 32'(req_ready), 1);
        check("run_idle_csb", 32'(mem_csb), 1);

        // Swept value readback
        resp_ready = 1'b1;
        issue(1'b0, 7'd0,   4'h0);
        issue(1'b0, 7'd64,  4'h0);
        issue(1'b0, 7'd127, 4'h0);
        drain_check("t1_sweep_rd");

        // Read-after-write, response one cycle after acceptance
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd3; req_wdata = 4'h5;
        #1;
        check("t2_wr_ready", 32'(req_ready), 1);
        check("t2_wr_csb",   32'(mem_csb),   0);
        check("t2_wr_web",   32'(mem_web),   0);
        tick();
        req_write = 1'b0; req_wdata = 4'h0;
        #1;
        check("t2_rd_ready", 32'(req_ready), 1);
        check("t2_rd_web",   32'(mem_web),   1);
        tick();
        req_valid = 1'b0;
        #1;
        check("t2_oeb_capture", 32'(mem_oeb),    0);
        check("t2_valid_early", 32'(resp_valid), 0);
        tick();
        check("t2_valid", 32'(resp_valid), 1);
        check("t2_rdata", 32'(resp_rdata), 'h5);
        check("t2_oeb_idle", 32'(mem_oeb), 1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("t2_popped", 32'(resp_valid), 0);
        exp_mem[3] = 4'h5;
        clear_queues();

        // Credit limit with resp_ready low
        issue(1'b1, 7'd0, 4'h1);
        issue(1'b1, 7'd1, 4'h2);
        issue(1'b1, 7'd2, 4'h3);
        issue(1'b1, 7'd3, 4'h4);
        tick();
        clear_queues();
        req_valid = 1'b1; req_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr = 7'(i);
            #1;
            check("t3_ready_credit", 32'(req_ready), 1);
            tick();
        end
        req_addr = 7'd3;
        #1;
        check("t3_ready_exhausted", 32'(req_ready), 0);
        tick();
        tick();
        check("t3_ready_held",  32'(req_ready),  0);
        check("t3_head_valid",  32'(resp_valid), 1);
        check("t3_head_rdata",  32'(resp_rdata), 'h1);
        resp_ready = 1'b1;
        #1;
        check("t3_no_comb_path", 32'(req_ready), 0);
        tick();
        check("t3_credit_back", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h2);
        exp_q.push_back(4'h3);
        exp_q.push_back(4'h4);
        drain_check("t3_order");

        // Sustained read throughput
        for (int i = 0; i < 20; i++) issue(1'b1, 7'(10 + i), 4'((i * 3 + 1) & 15));
        clear_queues();
        drops = 0;
        req_valid = 1'b1; req_write = 1'b0;
        for (int i = 0; i < 20; i++) begin
            req_addr = 7'(10 + i);
            exp_q.push_back(exp_mem[10 + i]);
            #1;
            if (!req_ready) drops++;
            tick();
        end
        req_valid = 1'b0;
        check("t4_ready_drops", drops, 0);
        w = 0;
        while (got_q.size() < 20 && w < 100) begin
            tick();
            w++;
        end
        check("t4_accepts", 32'(acc_cyc_q.size()), 20);
        for (int i = 0; i < 20 && i < got_cyc_q.size() && i < acc_cyc_q.size(); i++)
            check("t4_latency", got_cyc_q[i] - acc_cyc_q[i], 2);
        drain_check("t4_stream");

        // Alternating traffic under random backpressure
        bp_run = 1'b1;
        fork
            begin
                while (bp_run) begin
                    @(posedge clock);
                    #1;
                    resp_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 30; i++) begin
            issue(1'b1, 7'($urandom_range(0, 15)), 4'($urandom));
            issue(1'b0, 7'($urandom_range(0, 15)), 4'h0);
        end
        bp_run = 1'b0;
        tick();
        tick();
        resp_ready = 1'b1;
        drain_check("t5_scoreboard");
        check("t5_oeb_only_capture", oeb_bad, 0);
        check("t5_no_overflow", 32'(max_out <= int'(RD)), 1);

        // Reset mid-sweep
        resp_ready = 1'b0;
        reset = 1'b1;
        #1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        check("t6_sweep_at50", 32'(mem_a), 50);
        reset = 1'b1;
        #1;
        check("t6a_csb",   32'(mem_csb),    1);
        check("t6a_a",     32'(mem_a),      0);
        check("t6a_valid", 32'(resp_valid), 0);
        check("t6a_done",  32'(init_done),  0);
        tick();
        tick();
        check("t6a_csb_held", 32'(mem_csb), 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t6a_restart_a",   32'(mem_a),   0);
        check("t6a_restart_csb", 32'(mem_csb), 0);
        wait_init("t6a_init_cycles");

        // Reset with two responses buffered
        clear_queues();
        issue(1'b0, 7'd5, 4'h0);
        issue(1'b0, 7'd6, 4'h0);
        tick();
        check("t6b_buffered", 32'(resp_valid), 1);
        reset = 1'b1;
        #1;
        check("t6b_valid", 32'(resp_valid), 0);
        check("t6b_csb",   32'(mem_csb),    1);
        check("t6b_oeb",   32'(mem_oeb),    1);
        clear_queues();
        @(negedge clock);
        reset = 1'b0;
        #1;
        wait_init("t6b_init_cycles");
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t6b_no_stale_pops", 32'(got_q.size()), 0);
        check("t6b_no_stale_valid", 32'(resp_valid), 0);
        issue(1'b0, 7'd5, 4'h0);
        drain_check("t6b_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed unfinished expected finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sram128x4_req_ctrl.md
# sram128x4_req_ctrl

Request/response front-end that sits directly upstream of the 128x4 single-port SRAM macro and is the only agent driving its pins. It converts a valid/ready request stream (read or write) into the macro's chip-select, write-enable and output-enable controls, and captures read data into a small response FIFO. After reset it sweeps the whole array to a known value before accepting traffic.

## Interface
- `ADDR_W`, 7: address width; array depth is 2^ADDR_W.
- `DATA_W`, 4: word width.
- `RESP_DEPTH`, 3: response FIFO entries; minimum 3 for full read throughput.
- `INIT_EN`, 1: 1 runs the post-reset clear sweep, 0 goes straight to RUN.
- `INIT_VAL`, 0: `DATA_W`-bit value written by the sweep.

- `clock` in 1: the single clock; also drives the macro clock.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready` at posedge.
- `req_write` in 1: 1 write, 0 read.
- `req_addr` in `ADDR_W`: word address.
- `req_wdata` in `DATA_W`: write data.
- `resp_valid` out 1: FIFO head valid.
- `resp_ready` in 1: head popped when `resp_valid & resp_ready` at posedge.
- `resp_rdata` out `DATA_W`: FIFO head read data.
- `init_done` out 1: high in RUN.
- `mem_ce` out 1: macro clock, equal to `clock`.
- `mem_csb` out 1: macro chip select, active-low.
- `mem_web` out 1: macro write enable, active-low (1 = read).
- `mem_oeb` out 1: macro output enable, active-low.
- `mem_a` out `ADDR_W`: macro address.
- `mem_i` out `DATA_W`: macro write data.
- `mem_o` in `DATA_W`: macro read data; high-Z while `mem_oeb`=1.

## Operation
- States: INIT, RUN.
- Reset enters INIT, or RUN if `INIT_EN`=0.
  - Clears sweep counter, FIFO, read-pending flag and credit count (credits = `RESP_DEPTH`).
- Reset values:
  - `req_ready`=0, `resp_valid`=0, `init_done`=0 (1 if `INIT_EN`=0), `mem_csb`=1, `mem_web`=1, `mem_oeb`=1.
  - `mem_a` and `mem_i` = 0.
  - Macro pins are held idle for as long as `reset` is high.
- INIT:
  - Each cycle drives `mem_csb`=0, `mem_web`=0, `mem_a`=counter, `mem_i`=`INIT_VAL`; counter increments.
  - After the write to address 2^ADDR_W-1 (128 cycles), go to RUN.
  - `req_ready`=0 throughout INIT.
- RUN macro pins are combinational from the request port:
  - `mem_csb` = ~(`req_valid` & `req_ready`); `mem_web` = ~`req_write`; `mem_a` = `req_addr`; `mem_i` = `req_wdata`.
  - The macro performs the access on the same posedge that accepts the request.
- Reads and the response FIFO:
  - An accepted read sets a read-pending flag.
  - While the flag is set, `mem_oeb`=0 and `mem_o` is captured into the FIFO tail at the next posedge; otherwise `mem_oeb`=1 and `mem_o` is ignored.
- Writes produce no response.
- Credit accounting:
  - `req_ready` = RUN & (credits ≠ 0). Every accepted request (read or write) consumes a credit, even though writes produce no response.
  - A write's credit is returned at the next posedge; a read's credit is returned when its response is popped.
  - Next credits = credits − accept + pop + (write retired).
  - No combinational path from `resp_ready` to `req_ready`.
- FIFO:
  - Capture and pop in the same cycle are both honoured and order is preserved.
  - Capture into a full FIFO cannot occur; the credit scheme guarantees this, and the verification bench asserts it.
- Pointers wrap modulo `RESP_DEPTH`.
- Read-after-write to the same address in consecutive cycles returns the new data (the macro write completes at the earlier edge).

## Timing
- Read latency:
  - Accept at edge N; data captured at edge N+1; `resp_valid`=1 after N+1; earliest pop at edge N+2.
- Throughput:
  - One request per cycle sustained with `resp_ready` held high and `RESP_DEPTH`≥3.
  - With `resp_ready` low, at most `RESP_DEPTH` reads are outstanding.
- INIT lasts exactly 2^ADDR_W cycles; `req_ready` can first rise in the cycle after the last sweep write.
- Reset asserted mid-operation (INIT or RUN):
  - Outputs go to reset values immediately.
  - Outstanding responses are discarded.
  - The sweep restarts from address 0 after deassertion.

## Test plan
- Reset, `INIT_EN`=1, `INIT_VAL`=4'hA -> `init_done` rises exactly 128 cycles after reset deassertion; reading addresses 0, 64 and 127 returns 4'hA each.
- Write 4'h5 to address 3, then read address 3 on the next cycle -> `resp_rdata`=4'h5 with `resp_valid` high one cycle after the read is accepted.
- `resp_ready` held 0; four back-to-back reads to addresses 0..3 preloaded with 1,2,3,4 -> first three accepted, `req_ready`=0 on the fourth; raising `resp_ready` returns 1,2,3 in order, then the fourth is accepted.
- `resp_ready` held 1; 20 consecutive reads -> `req_ready` never drops; 20 responses arrive in order, each one cycle after acceptance.
- Alternating write/read stream with random `resp_ready` backpressure -> all reads match the scoreboard; no FIFO overflow; `mem_oeb`=0 only in read-capture cycles.
- `reset` pulsed at sweep address 50, and again with 2 responses buffered -> `resp_valid`=0 and `mem_csb`=1 during reset; sweep restarts at address 0; no stale responses emerge.
